// File: rtl/uart_tx_arbiter.sv
// Two-requester byte arbiter in front of a UART transmitter: round-robin with optional lock and lock timeout.
// Accept in IDLE, uart_wr one cycle later; at least 4 cycles between writes; ready is held low until the UART is idle.
module uart_tx_arbiter #(
    parameter int TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       resetq,
    input  logic       a_valid,
    input  logic [7:0] a_data,
    input  logic       a_lock,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic [7:0] b_data,
    input  logic       b_lock,
    output logic       b_ready,
    output logic       uart_wr,
    output logic [7:0] uart_dat,
    input  logic       uart_busy,
    output logic       owner,
    output logic       locked
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_START, WAIT_DONE} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_dat;
    logic          r_owner;
    logic          r_locked;
    logic [CW-1:0] r_cnt;

    logic w_arb_ok, w_elig_a, w_elig_b, w_sel_a, w_sel_b;
    logic w_xfer_a, w_xfer_b, w_xfer, w_own_vld, w_cnt_en, w_expire;

    // Selection looks only at the other side's valid, never its data or lock.
    assign w_arb_ok = resetq & (r_state == IDLE) & ~uart_busy;
    assign w_elig_a = ~r_locked | ~r_owner;
    assign w_elig_b = ~r_locked |  r_owner;
    assign w_sel_a  = r_locked | (a_valid & (~b_valid |  r_owner));
    assign w_sel_b  = r_locked | (b_valid & (~a_valid | ~r_owner));
    assign a_ready  = w_arb_ok & w_elig_a & w_sel_a;
    assign b_ready  = w_arb_ok & w_elig_b & w_sel_b;

    assign w_xfer_a = a_valid & a_ready;
    assign w_xfer_b = b_valid & b_ready;
    assign w_xfer   = w_xfer_a | w_xfer_b;

    assign w_own_vld = r_owner ? b_valid : a_valid;
    assign w_cnt_en  = (r_state == IDLE) & r_locked & ~uart_busy & ~w_own_vld;
    assign w_expire  = (TIMEOUT > 0) & r_locked & (r_cnt == TMAX);

    always_comb begin
        w_state_nxt = r_state;
        uart_wr     = 1'b0;
        case (r_state)
            IDLE:       if (w_xfer) w_state_nxt = SEND;
            SEND: begin
                uart_wr     = 1'b1;
                w_state_nxt = WAIT_START;
            end
            WAIT_START: w_state_nxt = WAIT_DONE;
            WAIT_DONE:  if (!uart_busy) w_state_nxt = IDLE;
            default:    w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetq) begin
            r_state  <= IDLE;
            r_dat    <= 8'h00;
            r_owner  <= 1'b1;
            r_locked <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            // A transfer in the expiry cycle takes precedence over the timeout.
            if (w_xfer) begin
                r_dat    <= w_xfer_b ? b_data : a_data;
                r_owner  <= w_xfer_b;
                r_locked <= w_xfer_b ? b_lock : a_lock;
            end else if (w_expire) begin
                r_locked <= 1'b0;
            end
            if (w_xfer || !r_locked) begin
                r_cnt <= '0;
            end else if (w_cnt_en && (r_cnt != TMAX)) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign uart_dat = r_dat;
    assign owner    = r_owner;
    assign locked   = r_locked;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1023: idle cycles a held lock survives without owner valid; 0 disables the timeout.
REQ-002 SHALL have port clk, input, 1: sole clock, all state updates on rising edge.
REQ-003 SHALL have port resetq, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have ports a_valid input 1, a_data input 8, a_lock input 1, a_ready output 1: requester A byte stream; a_lock=1 keeps grant after this byte.
REQ-005 SHALL have ports b_valid input 1, b_data input 8, b_lock input 1, b_ready output 1: requester B, same semantics as A.
REQ-006 SHALL have port uart_wr, output, 1: one-cycle write strobe to the transmitter.
REQ-007 SHALL have port uart_dat, output, 8: byte to the transmitter, valid while uart_wr high.
REQ-008 SHALL have port uart_busy, input, 1: transmitter busy; rises the cycle after uart_wr, low when idle.
REQ-009 SHALL have port owner, output, 1: 0=A, 1=B; last accepted requester.
REQ-010 SHALL have port locked, output, 1: high while a lock is held by owner.

Function
REQ-011 SHALL implement states IDLE, SEND, WAIT_START, WAIT_DONE.
REQ-012 IDLE: x_ready SHALL be combinational = (state==IDLE) & !uart_busy & eligible_x & selected_x; transfer on x_valid & x_ready.
REQ-013 Eligibility: when locked, only owner eligible; when unlocked, both eligible.
REQ-014 Selection unlocked: single valid requester wins; both valid -> requester != owner wins (round-robin).
REQ-015 At most one ready high per cycle; ready SHALL never depend on the other requester's data or lock.
REQ-016 On transfer: register data into uart_dat, owner<=winner, locked<=winner's lock, go to SEND.
REQ-017 SEND: uart_wr=1 for exactly one cycle (accept cycle N -> uart_wr cycle N+1), then WAIT_START.
REQ-018 WAIT_START: one cycle, uart_busy ignored, then WAIT_DONE.
REQ-019 WAIT_DONE: stay while uart_busy=1; on uart_busy=0 go to IDLE.
REQ-020 Minimum spacing between uart_wr pulses: 4 cycles even if uart_busy never rises.
REQ-021 uart_dat SHALL hold its value until the next transfer.
REQ-022 Lock release: transfer with lock=0 by owner clears locked after that byte.
REQ-023 Timeout counter, width $clog2(TIMEOUT+1), counts cycles in IDLE with locked=1, uart_busy=0, owner valid=0; clears on any transfer or when unlocked.
REQ-024 Counter reaching TIMEOUT (TIMEOUT>0) SHALL clear locked next cycle; counter SHALL not wrap.
REQ-025 Owner valid and timeout expiry in the same cycle: transfer wins, lock semantics per REQ-016.
REQ-026 valid dropped without ready: no transfer, no state change; requesters may withdraw.
REQ-027 uart_busy high in IDLE (external use): no ready, no timeout count.

Reset
REQ-028 resetq=0 at a clock edge SHALL set state=IDLE, uart_wr=0, uart_dat=0, owner=1, locked=0, counter=0.
REQ-029 Reset mid-SEND/WAIT SHALL abandon the sequence; an in-flight UART byte is not aborted by this block.
REQ-030 With resetq=0, a_ready=b_ready=0.

Verification
REQ-031 Both valid after reset, no lock, data A=0x41 B=0x42 -> A accepted first, uart_dat 0x41 then 0x42, owner 0 then 1.
REQ-032 A sends 3 bytes with lock=1,1,0 while B valid throughout -> uart sequence A,A,A then B; locked high across first two, low after third.
REQ-033 A sends lock=1 then drops valid, TIMEOUT=8 -> locked clears after 8 idle cycles, B accepted next eligible cycle.
REQ-034 Accept at cycle N with uart_busy model asserting 87 cycles from N+2 -> uart_wr high only at N+1, next ready not before busy falls.
REQ-035 resetq low during WAIT_DONE -> next cycle IDLE, uart_wr 0, locked 0, owner 1; A wins next contention.
REQ-036 uart_busy held low permanently, continuous A valid -> uart_wr every 4 cycles, never two consecutive.
